// File: rtl/zoom_stream_packer.sv
// Packs an 8-bit grayscale pixel stream into RGB565 beats through a
// first-word-fall-through FIFO with frame start/end tagging.
module zoom_stream_packer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    pixel_in,
  input  logic                          pixel_in_valid,
  input  logic                          out_ready,
  output logic [15:0]                   out_data,
  output logic                          out_valid,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [LW-1:0] L_FULL = LW'(FIFO_DEPTH);

  // entry layout: {pixel[7:0], sop_tag, eop_tag}
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          overflow_q, overflow_d;
  logic          frame_done_q, frame_done_d;

  logic [9:0] head;
  logic       full;
  logic       not_empty;
  logic       pop;
  logic       push;
  logic       drop;
  logic       sop_tag;
  logic       eop_tag;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    full      = (level_q == L_FULL);
    not_empty = (level_q != '0);
    pop       = not_empty && out_ready;
    push      = pixel_in_valid && (!full || pop);
    drop      = pixel_in_valid && full && !pop;
    sop_tag   = (x_q == '0) && (y_q == '0);
    eop_tag   = (x_q == X_LAST) && (y_q == Y_LAST);
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    x_d          = x_q;
    y_d          = y_q;
    overflow_d   = overflow_q | drop;
    frame_done_d = pop && head[0];

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // position advances on every valid pixel, dropped or not
    if (pixel_in_valid) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      x_q          <= x_d;
      y_q          <= y_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= {pixel_in, sop_tag, eop_tag};
    end
  end

  always_comb begin
    out_valid  = not_empty;
    out_data   = {head[9:5], head[9:4], head[9:5]};
    out_sop    = not_empty && head[1];
    out_eop    = not_empty && head[0];
    fifo_level = level_q;
    overflow   = overflow_q;
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_zoom_stream_packer.sv
// Scoreboard bench for zoom_stream_packer: driver predicts beats from
// pixel order and occupancy, monitor checks every output cycle.
module tb_zoom_stream_packer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int D  = 8;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    pixel_in = '0;
  logic          pixel_in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          frame_done;

  zoom_stream_packer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .FIFO_DEPTH(D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_in      (pixel_in),
    .pixel_in_valid(pixel_in_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    lvl = 0;
  bit    ovf = 1'b0;
  int    pix_cnt = 0;
  bit    mon_en = 1'b0;
  int    fd_pulses = 0;
  bit    fd_exp = 1'b0;
  bit    held = 1'b0;
  logic [17:0] held_beat = '0;

  function automatic logic [15:0] rgb565(input logic [7:0] p);
    int r;
    int g;
    r = int'(p) / 8;
    g = int'(p) / 4;
    return 16'((r * 2048) + (g * 32) + r);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv,
               $time);
    end
  endtask

  // One clock of stimulus; the model decides write/drop/pop up front.
  task automatic cycle(input bit v, input logic [7:0] p, input bit r);
    int    nl;
    int    idx;
    bit    pop;
    bit    wr;
    beat_t b;
    pixel_in_valid = v;
    pixel_in       = p;
    out_ready      = r;
    pop = r && (lvl > 0);
    wr  = v && ((lvl < D) || pop);
    nl  = lvl + (wr ? 1 : 0) - (pop ? 1 : 0);
    if (v) begin
      idx = pix_cnt % (W * H);
      pix_cnt++;
      if (wr) begin
        b.data = rgb565(p);
        b.sop  = (idx == 0);
        b.eop  = (idx == W * H - 1);
        exp_q.push_back(b);
      end
    end
    @(posedge clk);
    lvl = nl;
    if (v && !wr) ovf = 1'b1;
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      pixel_in_valid = 1'($urandom % 2);
      pixel_in       = 8'($urandom);
      out_ready      = 1'($urandom % 2);
      @(posedge clk);
      exp_q.delete();
      lvl     = 0;
      ovf     = 1'b0;
      pix_cnt = 0;
      #1;
    end
    reset          = 1'b0;
    pixel_in_valid = 1'b0;
    out_ready      = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && lvl > 0; i++) cycle(1'b0, 8'h00, 1'b1);
    check("drained_level", 32'(fifo_level), 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      beat_t b;
      check("out_valid", 32'(out_valid), 32'(lvl > 0));
      check("fifo_level", 32'(fifo_level), 32'(lvl));
      check("overflow", 32'(overflow), 32'(ovf));
      check("frame_done", 32'(frame_done), 32'(fd_exp));
      if (frame_done) fd_pulses++;
      if (!out_valid) begin
        check("sop_idle", 32'(out_sop), 32'd0);
        check("eop_idle", 32'(out_eop), 32'd0);
      end
      if (held && out_valid)
        check("held_beat", 32'({out_data, out_sop, out_eop}),
              32'(held_beat));
      fd_exp = 1'b0;
      if (out_valid && out_ready && !reset) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pop_unexpected: got beat %0h expected none",
                   out_data);
        end else begin
          b = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(b.data));
          check("out_sop", 32'(out_sop), 32'(b.sop));
          check("out_eop", 32'(out_eop), 32'(b.eop));
          fd_exp = b.eop;
        end
      end
      held      = out_valid && !out_ready && !reset;
      held_beat = {out_data, out_sop, out_eop};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    do_reset(3);
    mon_en = 1'b1;

    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b1, 8'h80, 1'b1);
    cycle(1'b1, 8'hFF, 1'b1);
    cycle(1'b1, 8'h13, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    do_reset(2);
    fd0 = fd_pulses;
    repeat (2 * W * H) cycle(1'b1, 8'($urandom), 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    check("frame_done_count", 32'(fd_pulses - fd0), 32'd2);

    do_reset(2);
    repeat (D + 3) cycle(1'b1, 8'($urandom), 1'b0);
    check("full_level", 32'(fifo_level), 32'(D));
    check("overflow_set", 32'(overflow), 32'd1);
    drain(4 * D);

    do_reset(2);
    repeat (D) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 8'($urandom), 1'b1);
    check("full_wr_pop_level", 32'(fifo_level), 32'(D));
    check("full_wr_pop_ovf", 32'(overflow), 32'd0);
    drain(4 * D);

    do_reset(2);
    repeat (2000)
      cycle(($urandom % 10) < 7, 8'($urandom), 1'($urandom % 2));
    drain(8 * D);

    do_reset(2);
    repeat (5) cycle(1'b1, 8'($urandom), 1'b0);
    do_reset(1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    cycle(1'b1, 8'h5A, 1'b1);
    check("post_rst_sop", 32'(out_sop), 32'd1);
    repeat (2) cycle(1'b0, 8'h00, 1'b1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule

// File: doc/zoom_stream_packer.md
ZOOM_STREAM_PACKER -- requirements
Module: zoom_stream_packer

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, FIFO entries; power of 2, at least 4.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 pixel_in  input  8  grayscale pixel from the zoom stage.
REQ-007 pixel_in_valid  input  1  pixel_in valid this cycle; no backpressure path to the source.
REQ-008 out_ready  input  1  downstream sink accepts the current beat.
REQ-009 out_data  output  16  RGB565 beat.
REQ-010 out_valid  output  1  out_data, out_sop and out_eop are valid.
REQ-011 out_sop  output  1  beat is the first pixel of a frame (x=0, y=0).
REQ-012 out_eop  output  1  beat is the last pixel of a frame (x=IMG_WIDTH-1, y=IMG_HEIGHT-1).
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  output  1  sticky; set when an input pixel is dropped.
REQ-015 frame_done  output  1  one-cycle pulse, registered.

Function
REQ-016 Write event: pixel_in_valid=1 and (fifo_level<FIFO_DEPTH or a pop occurs in the same cycle). Each written entry stores {pixel_in, sop_tag, eop_tag}.
REQ-017 Drop event: pixel_in_valid=1, FIFO full and no pop in the same cycle. The pixel is discarded and overflow is set to 1 on the next edge.
REQ-018 Position counters x (0..IMG_WIDTH-1) and y (0..IMG_HEIGHT-1) advance on every valid input pixel, written or dropped. x wraps to 0 at IMG_WIDTH-1 and increments y; y wraps to 0 after IMG_HEIGHT-1, so counters stay frame-aligned.
REQ-019 sop_tag=1 if and only if x=0 and y=0; eop_tag=1 if and only if x=IMG_WIDTH-1 and y=IMG_HEIGHT-1; both are evaluated at the write.
REQ-020 Pop event: out_valid=1 and out_ready=1.
REQ-021 FIFO is first-word-fall-through. out_valid=1 whenever fifo_level>0. out_data, out_sop and out_eop are driven from the head entry with no added register stage.
REQ-022 Latency: a pixel written at edge k appears on out_valid/out_data after edge k when the FIFO was empty (one cycle, input valid to output valid).
REQ-023 While out_valid=1 and out_ready=0, out_data, out_sop, out_eop and out_valid are held stable.
REQ-024 out_data = {p[7:3], p[7:2], p[7:3]}, where p is the stored pixel. This is pure bit replication, with no arithmetic.
REQ-025 fifo_level updates:
- +1 on a write without a pop.
- -1 on a pop without a write.
- unchanged on a simultaneous write and pop.
- never exceeds FIFO_DEPTH and never goes below 0.
REQ-026 Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally modulo FIFO_DEPTH.
REQ-027 A pop when empty is impossible because out_valid=0; out_ready while empty has no effect.
REQ-028 frame_done=1 for exactly one cycle on the edge after a pop of an entry with eop_tag=1; otherwise 0.
REQ-029 overflow clears only on reset; further drops leave it at 1.

Reset
REQ-030 While reset=1 the block holds the following values, and these hold in the cycle after reset deasserts:
- read and write pointers, x, y and fifo_level at 0.
- overflow and frame_done at 0.
- out_valid, out_sop and out_eop at 0.
REQ-031 out_data is don't-care while out_valid=0.
REQ-032 Reset asserted mid-frame discards all FIFO contents. The first valid pixel after reset is tagged sop.
REQ-033 Input pixels presented while reset=1 are ignored.

Verification
REQ-034 Reset, then 4 pixels 0x00,0x80,0xFF,0x13 with out_ready=1 -> beats 0x0000, 0x8410, 0xFFFF, 0x1082; first beat has out_sop=1; each beat appears one cycle after its input.
REQ-035 IMG_WIDTH=4, IMG_HEIGHT=2, two back-to-back frames, out_ready=1 -> out_sop on beats 0 and 8; out_eop on beats 7 and 15; frame_done pulses twice, one cycle after each eop beat.
REQ-036 out_ready=0, FIFO_DEPTH+3 continuous pixels -> fifo_level=FIFO_DEPTH; overflow=1; the first FIFO_DEPTH pixels are retained and later drain in order.
REQ-037 FIFO full, then pixel_in_valid=1 with out_ready=1 in the same cycle -> the pixel is written, fifo_level stays FIFO_DEPTH, overflow stays 0.
REQ-038 Random out_ready (50%) with a random valid input stream -> output order matches input order, held beats are stable, fifo_level matches a reference count.
REQ-039 reset pulsed after 5 pixels of a frame -> FIFO empties, out_valid=0; the next pixel is output with out_sop=1.
